drm_20x256_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one drm_20x256 simple-dual-port RAM (20-bit x 256) between NUM_REQ requesters.
- Write and read ports are arbitrated independently.
- Registers the RAM-side controls and tracks in-flight reads so each read result returns to its originator.
- Resolves same-cycle write/read address collisions as write-first.
- Sits between client logic and the RAM instance, with RAM wr_clk and rd_clk both tied to clk.

---
 rtl/drm_arb_pkg.sv | 40 ++++
 rtl/drm_rr_arb.sv | 59 +++++
 rtl/drm_20x256_arb.sv | 158 +++++++++++++++
 tb/tb_drm_20x256_arb.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drm_arb_pkg.sv
// -----------------------------------------------------------------------------
// drm_arb_pkg
// Shared definitions for the drm_20x256 RAM arbiter slice.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default RAM geometry (20 x 256).
//   MAX_REQ                         : widest requester vector rr_pick handles.
//   rd_lat(output_reg)              : RAM read latency in cycles (1 + OUTPUT_REG).
//   rr_pick(req, ptr, n)            : one-hot round-robin pick among n requesters,
//                                     searching upward from index ptr.
// -----------------------------------------------------------------------------
package drm_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 20;
  localparam int MAX_REQ        = 4;

  function automatic int rd_lat(input int output_reg);
    return 1 + output_reg;
  endfunction

  // The first requesting index at or after ptr (mod n) wins.
  // Bits at and above n are never set.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [1:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 j;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = (int'(ptr) + k) % n;
      if ((k < n) && !found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/drm_rr_arb.sv
// -----------------------------------------------------------------------------
// drm_rr_arb
// N-way round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req [N]    : request vector
//   upd        : advance the pointer past the current winner (driven with |gnt)
//   gnt [N]    : one-hot grant, combinational, forced to 0 while in reset
//   idx        : binary index of the granted requester (0 when no grant)
// The pointer holds the index with highest priority next cycle; it resets to 0
// and moves to (winner + 1) mod N only in cycles that carry a grant.
// -----------------------------------------------------------------------------
module drm_rr_arb
  import drm_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 2) ? 2 : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          upd,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [1:0]         ptr_q;
  logic [1:0]         next_ptr;
  logic [2:0]         idx_inc;
  logic [MAX_REQ-1:0] req_ext;
  logic [N-1:0]       pick;

  always_comb begin
    req_ext = MAX_REQ'(req);
    pick    = N'(rr_pick(req_ext, ptr_q, N));
    gnt     = rst_n ? pick : '0;
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) idx = IW'(i);
    end
  end

  always_comb begin
    idx_inc  = 3'(idx) + 3'd1;
    next_ptr = (idx_inc == 3'(N)) ? 2'd0 : idx_inc[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else if (upd) begin
      ptr_q <= next_ptr;
    end
  end

endmodule

// File: rtl/drm_20x256_arb.sv
// -----------------------------------------------------------------------------
// drm_20x256_arb
// Round-robin arbiter / sequencer sharing one drm_20x256 simple-dual-port RAM
// (wr_clk = rd_clk = clk) among NUM_REQ requesters. Writes and reads are
// arbitrated independently.
//
// Handshake: a client raises req[i] and holds it with its address/data until
// it sees gnt[i]; the transfer happens in the cycle where req[i] && gnt[i],
// and address/data are sampled in that cycle. Grants are combinational,
// one-hot, and only ever given to a requesting index. The read return path
// has no back-pressure: rd_valid[i] pulses for one cycle with rd_data.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data: per-requester write request, packed slices
//   wr_gnt                : one-hot write grant
//   rd_req/rd_addr        : per-requester read request, packed slices
//   rd_gnt                : one-hot read grant
//   rd_valid, rd_data     : one-hot read-return strobe and shared return data
//   ram_wr_en/addr/data   : registered RAM write port controls
//   ram_rd_addr           : registered RAM read address (holds when idle)
//   ram_rd_data           : RAM read data
//
// Timing (read accepted in cycle T): ram_rd_addr in T+1, return in
// T+2+OUTPUT_REG. Write accepted in T: ram_wr_en/addr/data in T+1.
// A write and a read reaching the RAM ports in the same cycle at the same
// address return the write data (write-first) via a bypass carried down the
// in-flight pipeline.
// -----------------------------------------------------------------------------
module drm_20x256_arb
  import drm_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = 2,
  parameter int OUTPUT_REG = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          ram_wr_en,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_data,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

  localparam int IW     = (NUM_REQ > 2) ? 2 : 1;
  localparam int RD_LAT = rd_lat(OUTPUT_REG);
  localparam int LAST   = RD_LAT - 1;

  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          wr_any;
  logic          rd_any;
  logic          collide;

  // Stage 0: read sitting at the RAM address port this cycle.
  logic                 s0_vld;
  logic [NUM_REQ-1:0]   s0_id;
  // Return stages: waiting for RAM data; index LAST drives the outputs.
  logic                 ret_vld  [RD_LAT];
  logic [NUM_REQ-1:0]   ret_id   [RD_LAT];
  logic                 ret_byp  [RD_LAT];
  logic [DATA_WIDTH-1:0] ret_bdat [RD_LAT];

  assign wr_any = |wr_gnt;
  assign rd_any = |rd_gnt;

  drm_rr_arb #(.N(NUM_REQ)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .upd   (wr_any),
    .gnt   (wr_gnt),
    .idx   (wr_idx)
  );

  drm_rr_arb #(.N(NUM_REQ)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .upd   (rd_any),
    .gnt   (rd_gnt),
    .idx   (rd_idx)
  );

  // Write port: one registered stage from grant to RAM. Address/data only
  // matter when ram_wr_en is high, so they simply hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_wr_en <= wr_any;
      if (wr_any) begin
        ram_wr_addr <= wr_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wr_data <= wr_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Same-RAM-cycle collision. Earlier writes are already in the array.
  assign collide = ram_wr_en && (ram_wr_addr == ram_rd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_addr <= '0;
      s0_vld      <= 1'b0;
      s0_id       <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        ret_vld[i]  <= 1'b0;
        ret_id[i]   <= '0;
        ret_byp[i]  <= 1'b0;
        ret_bdat[i] <= '0;
      end
    end else begin
      if (rd_any) begin
        ram_rd_addr <= rd_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      s0_vld <= rd_any;
      s0_id  <= rd_gnt;
      // The bypass decision is taken while the read is at the RAM port and
      // then travels with the read until it is returned.
      ret_vld[0]  <= s0_vld;
      ret_id[0]   <= s0_id;
      ret_byp[0]  <= s0_vld && collide;
      ret_bdat[0] <= ram_wr_data;
      for (int i = 1; i < RD_LAT; i++) begin
        ret_vld[i]  <= ret_vld[i-1];
        ret_id[i]   <= ret_id[i-1];
        ret_byp[i]  <= ret_byp[i-1];
        ret_bdat[i] <= ret_bdat[i-1];
      end
    end
  end

  // RAM data arrives in the same cycle as the last stage, so the return is a
  // combinational select gated by that stage's valid.
  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    if (ret_vld[LAST]) begin
      rd_valid = ret_id[LAST];
      rd_data  = ret_byp[LAST] ? ret_bdat[LAST] : ram_rd_data;
    end
  end

endmodule

// File: tb/tb_drm_20x256_arb.sv
// -----------------------------------------------------------------------------
// tb_drm_20x256_arb
// Two arbiter instances (OUTPUT_REG=0 and OUTPUT_REG=1) driven by the same
// client stimulus, each attached to a behavioural 20x256 RAM that returns the
// old contents on a same-cycle write/read collision. A reference model keeps
// the memory image, the round-robin pointers and the queue of expected read
// returns, and is evaluated once per cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_drm_20x256_arb;

  localparam int NR = 2;
  localparam int AW = 8;
  localparam int DW = 20;
  localparam int EW = 32 + 2 + DW;   // {due cycle, requester index, data}

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT wiring
  logic [NR-1:0]    wr_req, rd_req;
  logic [NR*AW-1:0] wr_addr, rd_addr;
  logic [NR*DW-1:0] wr_data;

  logic [NR-1:0] wr_gnt0, rd_gnt0, rd_valid0;
  logic [DW-1:0] rd_data0, ram_wr_data0, ram_rd_data0;
  logic [AW-1:0] ram_wr_addr0, ram_rd_addr0;
  logic          ram_wr_en0;

  logic [NR-1:0] wr_gnt1, rd_gnt1, rd_valid1;
  logic [DW-1:0] rd_data1, ram_wr_data1, ram_rd_data1;
  logic [AW-1:0] ram_wr_addr1, ram_rd_addr1;
  logic          ram_wr_en1;

  drm_20x256_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .OUTPUT_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt0),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt0),
    .rd_valid(rd_valid0), .rd_data(rd_data0),
    .ram_wr_en(ram_wr_en0), .ram_wr_addr(ram_wr_addr0), .ram_wr_data(ram_wr_data0),
    .ram_rd_addr(ram_rd_addr0), .ram_rd_data(ram_rd_data0)
  );

  drm_20x256_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .OUTPUT_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt1),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt1),
    .rd_valid(rd_valid1), .rd_data(rd_data1),
    .ram_wr_en(ram_wr_en1), .ram_wr_addr(ram_wr_addr1), .ram_wr_data(ram_wr_data1),
    .ram_rd_addr(ram_rd_addr1), .ram_rd_data(ram_rd_data1)
  );

  // Behavioural RAMs: read-old on collision, so only the arbiter's bypass can
  // produce write-first data.
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] rq0, rq1a, rq1b;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (ram_wr_en0) mem0[ram_wr_addr0] <= ram_wr_data0;
    rq0 <= mem0[ram_rd_addr0];
    if (ram_wr_en1) mem1[ram_wr_addr1] <= ram_wr_data1;
    rq1a <= mem1[ram_rd_addr1];
    rq1b <= rq1a;
  end
  assign ram_rd_data0 = rq0;
  assign ram_rd_data1 = rq1b;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  logic [DW-1:0] m_mem [256];
  int            m_wptr, m_rptr;
  logic          prev_w, prev_r;
  logic [AW-1:0] prev_waddr, prev_raddr;
  logic [DW-1:0] prev_wdata;
  logic [EW-1:0] exp_q0 [$];
  logic [EW-1:0] exp_q1 [$];
  logic [NR-1:0] last_wg, last_rg;

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_wptr = 0; m_rptr = 0;
    prev_w = 1'b0; prev_r = 1'b0;
    prev_waddr = '0; prev_raddr = '0; prev_wdata = '0;
    last_wg = '0; last_rg = '0;
  end

  // Highest priority goes to the index after the last one granted.
  function automatic int rr_model(input logic [NR-1:0] req, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (req[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic sb_cycle();
    int            jw, jr;
    logic [NR-1:0] ewg, erg;
    logic [AW-1:0] a;
    logic [EW-1:0] e;
    if (!rst_n) begin
      chk("rst_wr_gnt",      32'(wr_gnt0),      0);
      chk("rst_rd_gnt",      32'(rd_gnt0),      0);
      chk("rst_rd_valid_l1", 32'(rd_valid0),    0);
      chk("rst_rd_valid_l2", 32'(rd_valid1),    0);
      chk("rst_rd_data_l1",  32'(rd_data0),     0);
      chk("rst_rd_data_l2",  32'(rd_data1),     0);
      chk("rst_ram_wr_en",   32'(ram_wr_en0),   0);
      chk("rst_ram_wr_en_l2",32'(ram_wr_en1),   0);
      chk("rst_ram_wr_addr", 32'(ram_wr_addr0), 0);
      chk("rst_ram_wr_data", 32'(ram_wr_data0), 0);
      chk("rst_ram_rd_addr", 32'(ram_rd_addr0), 0);
      m_wptr = 0; m_rptr = 0;
      prev_w = 1'b0; prev_r = 1'b0;
      exp_q0.delete(); exp_q1.delete();
      last_wg = '0; last_rg = '0;
    end else begin
      // RAM ports carry last cycle's accepted transfers.
      chk("ram_wr_en", 32'(ram_wr_en0), 32'(prev_w));
      chk("ram_wr_en_l2", 32'(ram_wr_en1), 32'(prev_w));
      if (prev_w) begin
        chk("ram_wr_addr", 32'(ram_wr_addr0), 32'(prev_waddr));
        chk("ram_wr_data", 32'(ram_wr_data0), 32'(prev_wdata));
      end
      if (prev_r) chk("ram_rd_addr", 32'(ram_rd_addr0), 32'(prev_raddr));

      // Read returns, in issue order, exactly on their due cycle.
      if (exp_q0.size() > 0 && exp_q0[0][EW-1:DW+2] == 32'(cyc)) begin
        e = exp_q0.pop_front();
        chk("rd_valid_l1", 32'(rd_valid0), 32'(1) << e[DW+1:DW]);
        chk("rd_data_l1",  32'(rd_data0),  32'(e[DW-1:0]));
      end else begin
        chk("rd_idle_l1", 32'(rd_valid0), 0);
      end
      if (exp_q1.size() > 0 && exp_q1[0][EW-1:DW+2] == 32'(cyc)) begin
        e = exp_q1.pop_front();
        chk("rd_valid_l2", 32'(rd_valid1), 32'(1) << e[DW+1:DW]);
        chk("rd_data_l2",  32'(rd_data1),  32'(e[DW-1:0]));
      end else begin
        chk("rd_idle_l2", 32'(rd_valid1), 0);
      end

      // Write arbitration; an accepted write is visible to a read accepted in
      // the same cycle (write-first) and to everything later.
      jw = rr_model(wr_req, m_wptr);
      ewg = '0;
      if (jw >= 0) ewg[jw] = 1'b1;
      chk("wr_gnt",    32'(wr_gnt0), 32'(ewg));
      chk("wr_gnt_l2", 32'(wr_gnt1), 32'(ewg));
      prev_w = (jw >= 0);
      if (jw >= 0) begin
        prev_waddr = wr_addr[jw*AW +: AW];
        prev_wdata = wr_data[jw*DW +: DW];
        m_mem[prev_waddr] = prev_wdata;
        m_wptr = (jw + 1) % NR;
      end

      jr = rr_model(rd_req, m_rptr);
      erg = '0;
      if (jr >= 0) erg[jr] = 1'b1;
      chk("rd_gnt",    32'(rd_gnt0), 32'(erg));
      chk("rd_gnt_l2", 32'(rd_gnt1), 32'(erg));
      prev_r = (jr >= 0);
      if (jr >= 0) begin
        a = rd_addr[jr*AW +: AW];
        prev_raddr = a;
        exp_q0.push_back({32'(cyc + 2), 2'(jr), m_mem[a]});
        exp_q1.push_back({32'(cyc + 3), 2'(jr), m_mem[a]});
        m_rptr = (jr + 1) % NR;
      end
      last_wg = ewg;
      last_rg = erg;
    end
    cyc++;
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic cycle();
    @(negedge clk);
    sb_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr_req = '0;
    rd_req = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 5);
    return (r < 4) ? AW'(r) : AW'(8'hFA + r);
  endfunction

  // ---------------------------------------------------------------- sequence
  initial begin
    int cnt0, cnt1;
    rst_n = 1'b1;
    wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b1;
    idle(2);

    // Fill every address from requester 0, then read all of it back.
    for (int a = 0; a < 256; a++) begin
      wr_req = 2'b01;
      set_wr(0, AW'(a), DW'(20'hFFFFF - a));
      cycle();
    end
    idle(2);
    for (int a = 0; a < 256; a++) begin
      rd_req = 2'b01;
      set_rd(0, AW'(a));
      cycle();
    end
    idle(4);

    // Both writers requesting continuously share the port equally.
    cnt0 = 0; cnt1 = 0;
    set_wr(0, 8'h30, 20'h0A0A0);
    set_wr(1, 8'h31, 20'h0B0B0);
    wr_req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      cycle();
      cnt0 += int'(last_wg[0]);
      cnt1 += int'(last_wg[1]);
    end
    chk("rr_grants_req0", 32'(cnt0), 4);
    chk("rr_grants_req1", 32'(cnt1), 4);
    idle(2);

    // Write and read of the same address meet at the RAM in one cycle.
    wr_req = 2'b01; set_wr(0, 8'h10, 20'h00000);
    cycle();
    idle(2);
    wr_req = 2'b01; set_wr(0, 8'h10, 20'h12345);
    rd_req = 2'b10; set_rd(1, 8'h10);
    cycle();
    idle(4);

    // Alternating readers, back-to-back returns.
    wr_req = 2'b01; set_wr(0, 8'h01, 20'hAAAAA); cycle();
    wr_req = 2'b01; set_wr(0, 8'h02, 20'h55555); cycle();
    idle(2);
    set_rd(0, 8'h01); set_rd(1, 8'h02);
    rd_req = 2'b11;
    for (int i = 0; i < 8; i++) cycle();
    idle(4);

    // Reset one cycle after a read grant: that read must never return.
    rd_req = 2'b01; set_rd(0, 8'h05);
    cycle();
    rd_req = 2'b00;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle(5);
    wr_req = 2'b11; rd_req = 2'b11;
    set_wr(0, 8'h40, 20'h11111); set_wr(1, 8'h41, 20'h22222);
    set_rd(0, 8'h01); set_rd(1, 8'h02);
    cycle();
    chk("post_rst_wr_first", 32'(last_wg), 32'(2'b01));
    chk("post_rst_rd_first", 32'(last_rg), 32'(2'b01));
    wr_req = 2'b10; rd_req = 2'b10;
    cycle();
    idle(4);

    // Randomized traffic on a few hot addresses (including 0xFF).
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!wr_req[i] || last_wg[i]) begin
          wr_req[i] = ($urandom_range(0, 99) < 60);
          set_wr(i, rand_addr(), DW'($urandom));
        end
        if (!rd_req[i] || last_rg[i]) begin
          rd_req[i] = ($urandom_range(0, 99) < 60);
          set_rd(i, rand_addr());
        end
      end
      cycle();
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
